// File: rtl/fifo_wr_arbiter_if.sv
// Write-side bundle between the requesters, the round-robin arbiter and the FIFO.
// The arbiter is the master: it drives the FIFO write strobe, the data, the per-requester ready and the status.
interface fifo_wr_arbiter_if #(
  parameter int DATA_WIDTH = 8,
  parameter int NUM_REQ    = 4
);
  localparam int IW = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]            req_valid;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
  logic [NUM_REQ-1:0]            req_ready;
  logic                          full;
  logic                          wr_en;
  logic [DATA_WIDTH-1:0]         wr_data;
  logic [IW-1:0]                 grant_id;
  logic                          busy;

  modport master (
    input  req_valid, req_data, full,
    output req_ready, wr_en, wr_data, grant_id, busy
  );

  modport slave (
    output req_valid, req_data, full,
    input  req_ready, wr_en, wr_data, grant_id, busy
  );
endinterface

// File: rtl/fifo_wr_arbiter.sv
// Round-robin owner of the async FIFO write port.
// Each grant lasts for up to BURST_LEN words; the whole block runs in the write-clock domain.
module fifo_wr_arbiter #(
  parameter int DATA_WIDTH = 8,
  parameter int NUM_REQ    = 4,
  parameter int BURST_LEN  = 4
) (
  input  logic               wr_clk,
  input  logic               wr_rst,
  fifo_wr_arbiter_if.master  bus
);
  localparam int IW = $clog2(NUM_REQ);
  localparam int BW = $clog2(BURST_LEN + 1);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t          r_state;
  logic [IW-1:0]   r_owner;
  logic [IW-1:0]   r_last_owner;
  logic [BW-1:0]   r_beats;

  logic                  w_busy;
  logic                  w_owner_valid;
  logic                  w_grant_ok;
  logic                  w_wr_en;
  logic                  w_release;
  logic                  w_found;
  logic [IW-1:0]         w_ref;
  logic [IW-1:0]         w_pick;
  logic [IW:0]           w_idx;
  logic [NUM_REQ-1:0]    w_ready;
  logic [DATA_WIDTH-1:0] w_data;

  assign w_busy        = (r_state == GRANT);
  assign w_owner_valid = bus.req_valid[r_owner];
  assign w_grant_ok    = w_busy && !bus.full && !wr_rst;
  assign w_wr_en       = w_grant_ok && w_owner_valid;
  assign w_release     = (w_wr_en && (r_beats == BW'(BURST_LEN - 1))) || !w_owner_valid;

  // Search starts one past the reference and wraps, so the reference itself is tried last.
  always_comb begin
    w_ref   = w_busy ? r_owner : r_last_owner;
    w_found = 1'b0;
    w_pick  = '0;
    w_idx   = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      w_idx = {1'b0, w_ref} + (IW+1)'(k);
      if (w_idx >= (IW+1)'(NUM_REQ))
        w_idx = w_idx - (IW+1)'(NUM_REQ);
      if (!w_found && bus.req_valid[w_idx[IW-1:0]]) begin
        w_found = 1'b1;
        w_pick  = w_idx[IW-1:0];
      end
    end
  end

  always_comb begin
    w_ready = '0;
    w_data  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (r_owner == IW'(i)) begin
        w_ready[i] = w_grant_ok;
        w_data     = bus.req_data[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  always_ff @(posedge wr_clk) begin
    if (wr_rst) begin
      r_state      <= IDLE;
      r_owner      <= '0;
      r_beats      <= '0;
      r_last_owner <= IW'(NUM_REQ - 1);
    end else begin
      case (r_state)
        IDLE: begin
          if (w_found) begin
            r_state      <= GRANT;
            r_owner      <= w_pick;
            r_last_owner <= w_pick;
            r_beats      <= '0;
          end
        end
        GRANT: begin
          if (w_release) begin
            r_beats <= '0;
            if (w_found) begin
              r_owner      <= w_pick;
              r_last_owner <= w_pick;
            end else begin
              r_state <= IDLE;
            end
          end else if (w_wr_en) begin
            r_beats <= r_beats + BW'(1);
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.req_ready = w_ready;
  assign bus.wr_en     = w_wr_en;
  assign bus.wr_data   = w_data;
  assign bus.grant_id  = r_owner;
  assign bus.busy      = w_busy;
endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter: a per-requester word-queue model predicts every output each cycle,
// and literal per-cycle expectations pin the reset, single-requester, rotation, stall, drop and mid-burst reset cases.
module tb_fifo_wr_arbiter;
  localparam int DW = 8;
  localparam int NR = 4;
  localparam int BL = 4;

  logic wr_clk = 1'b0;
  logic wr_rst;
  always #5 wr_clk = ~wr_clk;

  fifo_wr_arbiter_if #(.DATA_WIDTH(DW), .NUM_REQ(NR)) bus ();

  fifo_wr_arbiter #(.DATA_WIDTH(DW), .NUM_REQ(NR), .BURST_LEN(BL)) dut (
    .wr_clk (wr_clk),
    .wr_rst (wr_rst),
    .bus    (bus)
  );

  logic [DW-1:0] q [NR][$];
  bit            en [NR];
  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // Model: who holds the port, how many words of the burst are used, last granted requester.
  bit m_busy  = 1'b0;
  int m_owner = 0;
  int m_used  = 0;
  int m_last  = NR - 1;

  logic          lg_en   [int];
  logic          lg_busy [int];
  int            lg_gid  [int];
  logic [NR-1:0] lg_rdy  [int];
  logic [DW-1:0] lg_dat  [int];

  logic          e_en;
  logic [NR-1:0] e_rdy;
  logic [DW-1:0] e_dat;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int next_after(input int r, input logic [NR-1:0] v);
    for (int k = 1; k <= NR; k++)
      if (v[(r + k) % NR]) return (r + k) % NR;
    return -1;
  endfunction

  always @(negedge wr_clk) begin
    e_rdy = '0;
    if (m_busy && !bus.full && !wr_rst) e_rdy[m_owner] = 1'b1;
    e_en  = e_rdy[m_owner] && bus.req_valid[m_owner];
    e_dat = bus.req_data[m_owner*DW +: DW];
    chk("wr_en",     {31'd0, bus.wr_en}, {31'd0, e_en});
    chk("req_ready", {28'd0, bus.req_ready}, {28'd0, e_rdy});
    chk("busy",      {31'd0, bus.busy}, {31'd0, m_busy});
    chk("grant_id",  {30'd0, bus.grant_id}, 32'(m_owner));
    chk("wr_data",   {24'd0, bus.wr_data}, {24'd0, e_dat});
    lg_en[cyc]   = bus.wr_en;
    lg_busy[cyc] = bus.busy;
    lg_gid[cyc]  = int'(bus.grant_id);
    lg_rdy[cyc]  = bus.req_ready;
    lg_dat[cyc]  = bus.wr_data;
  end

  task automatic model_edge();
    logic [NR-1:0] v;
    bit acc;
    int nx;
    v = bus.req_valid;
    if (wr_rst) begin
      m_busy = 1'b0; m_owner = 0; m_used = 0; m_last = NR - 1;
    end else if (!m_busy) begin
      nx = next_after(m_last, v);
      if (nx >= 0) begin
        m_busy = 1'b1; m_owner = nx; m_last = nx; m_used = 0;
      end
    end else begin
      acc = !bus.full && v[m_owner];
      if (acc) begin
        m_used++;
        void'(q[m_owner].pop_front());
      end
      if ((acc && m_used == BL) || !v[m_owner]) begin
        nx = next_after(m_owner, v);
        m_used = 0;
        if (nx >= 0) begin
          m_owner = nx; m_last = nx;
        end else begin
          m_busy = 1'b0;
        end
      end
    end
  endtask

  task automatic drive();
    for (int i = 0; i < NR; i++) begin
      bus.req_valid[i] = en[i] && (q[i].size() > 0);
      bus.req_data[i*DW +: DW] = (q[i].size() > 0) ? q[i][0] : '0;
    end
  endtask

  task automatic tick();
    @(posedge wr_clk);
    model_edge();
    cyc++;
    #1;
    drive();
  endtask

  task automatic load(input int id, input logic [DW-1:0] base, input int n);
    for (int k = 0; k < n; k++) q[id].push_back(DW'(base + DW'(k)));
  endtask

  task automatic do_reset();
    wr_rst = 1'b1;
    bus.full = 1'b0;
    for (int i = 0; i < NR; i++) begin
      q[i].delete();
      en[i] = 1'b1;
    end
    drive();
    tick();
    wr_rst = 1'b0;
    drive();
  endtask

  task automatic pin(input string name, input int c, input logic pen, input int gid, input logic [DW-1:0] dat);
    chk({name, "_en"},  {31'd0, lg_en[c]}, {31'd0, pen});
    chk({name, "_gid"}, 32'(lg_gid[c]), 32'(gid));
    if (pen) chk({name, "_dat"}, {24'd0, lg_dat[c]}, {24'd0, dat});
  endtask

  int s;

  initial begin
    wr_rst = 1'b1;
    bus.full = 1'b0;
    bus.req_valid = '0;
    bus.req_data = '0;
    for (int i = 0; i < NR; i++) begin
      en[i] = 1'b1;
      load(i, DW'(i * 16), 8);
    end
    drive();

    // Reset held two edges with everyone valid, then continuous rotation.
    tick(); tick();
    wr_rst = 1'b0;
    drive();
    repeat (21) tick();
    chk("rst_busy", {31'd0, lg_busy[1]}, 32'd0);
    chk("rst_rdy",  {28'd0, lg_rdy[1]}, 32'd0);
    pin("rst", 1, 1'b0, 0, '0);
    pin("arb_cycle", 2, 1'b0, 0, '0);
    for (int c = 3; c <= 22; c++) begin
      int b;
      b = (c - 3) / 4;
      pin("rot", c, 1'b1, b % 4, DW'(((b % 4) * 16) + (b / 4) * 4 + (c - 3) % 4));
    end

    // Single requester: six words through two back-to-back grants.
    do_reset();
    load(2, 8'hA0, 6);
    drive();
    s = cyc;
    repeat (9) tick();
    pin("single_idle", s, 1'b0, 0, '0);
    for (int k = 0; k < 6; k++) pin("single", s + 1 + k, 1'b1, 2, DW'(8'hA0 + k));
    pin("single_drop", s + 7, 1'b0, 2, '0);
    chk("single_busy_end", {31'd0, lg_busy[s + 8]}, 32'd0);

    // Full stall after two beats of requester 1.
    do_reset();
    load(1, 8'hB0, 4);
    load(2, 8'hC0, 4);
    drive();
    s = cyc;
    repeat (3) tick();
    bus.full = 1'b1;
    drive();
    repeat (3) tick();
    bus.full = 1'b0;
    drive();
    repeat (9) tick();
    pin("stall_b0", s + 1, 1'b1, 1, 8'hB0);
    pin("stall_b1", s + 2, 1'b1, 1, 8'hB1);
    for (int c = 3; c <= 5; c++) begin
      pin("stall", s + c, 1'b0, 1, '0);
      chk("stall_rdy", {28'd0, lg_rdy[s + c]}, 32'd0);
    end
    pin("stall_b2", s + 6, 1'b1, 1, 8'hB2);
    pin("stall_b3", s + 7, 1'b1, 1, 8'hB3);
    for (int k = 0; k < 4; k++) pin("stall_next", s + 8 + k, 1'b1, 2, DW'(8'hC0 + k));

    // Owner 0 drops valid after two beats while requester 3 waits.
    do_reset();
    load(0, 8'hD0, 6);
    load(3, 8'hE0, 4);
    drive();
    s = cyc;
    repeat (3) tick();
    en[0] = 1'b0;
    drive();
    repeat (6) tick();
    pin("drop_d0", s + 1, 1'b1, 0, 8'hD0);
    pin("drop_d1", s + 2, 1'b1, 0, 8'hD1);
    pin("drop_gap", s + 3, 1'b0, 0, '0);
    for (int k = 0; k < 4; k++) pin("drop_next", s + 4 + k, 1'b1, 3, DW'(8'hE0 + k));

    // Reset after beat 1 of owner 2; requester 0 appears during reset and must win next.
    do_reset();
    load(2, 8'hF0, 6);
    drive();
    s = cyc;
    repeat (2) tick();
    wr_rst = 1'b1;
    load(0, 8'h50, 4);
    drive();
    tick();
    wr_rst = 1'b0;
    drive();
    repeat (3) tick();
    pin("mrst_f0", s + 1, 1'b1, 2, 8'hF0);
    pin("mrst_cut", s + 2, 1'b0, 2, '0);
    chk("mrst_rdy", {28'd0, lg_rdy[s + 2]}, 32'd0);
    chk("mrst_idle", {31'd0, lg_busy[s + 3]}, 32'd0);
    pin("mrst_next", s + 4, 1'b1, 0, 8'h50);

    repeat (6) tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/fifo_wr_arbiter.md
# fifo_wr_arbiter

Round-robin write-port arbiter that shares the write side of the team's asynchronous FIFO (`asyn_FIFO`) among NUM_REQ requesters. Each requester owns the port for a burst of up to BURST_LEN words, then ownership rotates. The block runs entirely in the FIFO write-clock domain. It drives the FIFO `wr_en`/`wr_data` and honours the FIFO `full` flag, so the FIFO never sees a write while full.

## Interface
Parameters:
- DATA_WIDTH, 8, word width; matches the FIFO data width.
- NUM_REQ, 4, number of requesters (≥2).
- BURST_LEN, 4, maximum consecutive words per grant (≥1).

Ports:
- wr_clk  in  1  write-domain clock; the only clock in the block.
- wr_rst  in  1  synchronous, active-high reset.
- req_valid  in  NUM_REQ  bit i: requester i has a word.
- req_data  in  NUM_REQ*DATA_WIDTH  requester i word at bits [i*DATA_WIDTH +: DATA_WIDTH].
- req_ready  out  NUM_REQ  bit i: requester i word accepted this cycle if valid.
- full  in  1  FIFO full flag (write domain).
- wr_en  out  1  FIFO write enable.
- wr_data  out  DATA_WIDTH  FIFO write data.
- grant_id  out  $clog2(NUM_REQ)  current/last owner index.
- busy  out  1  high while a grant is held.

## Operation
- Registered state: `state` ∈ {IDLE, GRANT}, `owner` (drives grant_id), `beats` counter (0..BURST_LEN), `last_owner`.
- Reset values: IDLE, owner=0, beats=0, last_owner=NUM_REQ-1, so requester 0 has first priority.
- Outputs are combinational from state:
  - busy = (state==GRANT).
  - req_ready[i] = busy && owner==i && !full && !wr_rst.
  - wr_en = req_valid[owner] && req_ready[owner].
  - wr_data = req_data slice of owner. Data is don't-care when wr_en=0, but is driven from the owner slice.
- Transfer: on a wr_clk edge where wr_en=1, the word is written to the FIFO and beats increments.
- Arbitration pick: search requesters starting at (ref+1) mod NUM_REQ and wrapping, taking the first with req_valid=1.
  - In IDLE, ref=last_owner.
  - On release, ref=owner. The current owner is searched last, so it is re-granted only if it is the sole valid requester.
- IDLE: if any req_valid, set owner=pick, last_owner=pick, beats=0, and go to GRANT; otherwise stay. No transfer occurs in IDLE.
- GRANT release conditions, evaluated at the edge:
  - (a) a transfer completes beat number BURST_LEN; or
  - (b) req_valid[owner]=0.
- On release: if any req_valid (after excluding the owner's completing beat), re-arbitrate in the same edge: owner=pick, beats=0, stay in GRANT. Otherwise go to IDLE.
- Stall: full=1 with the owner valid holds owner and beats. There is no release and no rotation while stalled.
- Requesters must hold req_valid and data stable until accepted. Dropping valid forfeits the remainder of the burst.

## Timing
- Request to first write: 1 cycle from IDLE (arbitration cycle). 0 extra cycles on back-to-back bursts.
- Sustained throughput is 1 word/cycle when any requester is valid and full=0.
- full is sampled combinationally in the same cycle as the write. This gives no overrun even when the FIFO holds depth-1 words.
- The release-by-drop cycle (b) produces one idle write cycle.
- wr_rst high:
  - wr_en and req_ready are forced to 0 combinationally that same cycle.
  - All state returns to reset values at the edge, abandoning any partial burst. The abandoned requester gets no priority credit.
- Beat counter width: $clog2(BURST_LEN+1). Owner index arithmetic is modulo NUM_REQ with wrap from NUM_REQ-1 to 0.

## Test plan
- Reset: hold wr_rst 2 cycles with all req_valid=1 -> wr_en=0, req_ready=0, busy=0, grant_id=0 throughout. First write is from requester 0, one cycle after wr_rst falls.
- Single requester: req_valid=4'b0100 with 6 words A0..A5, BURST_LEN=4:
  - 1 idle cycle, then 4 writes A0..A3.
  - Immediate re-grant to 2 with no bubble, then writes A4, A5; then IDLE.
- Rotation: all four valid continuously, full=0 -> grant_id sequence 0,1,2,3,0, each held exactly 4 cycles. wr_en is high every cycle after the first.
- Full stall: full=1 for 3 cycles after beat 2 of requester 1's burst:
  - wr_en=0 and req_ready=0 for those cycles; grant_id stays 1.
  - 2 more beats follow, then rotation to 2.
- Drop: owner 0 drops valid after 2 beats while req 3 valid -> one cycle with wr_en=0, then grant_id=3 and its writes.
- Reset mid-burst: assert wr_rst after beat 1 of owner 2 -> wr_en=0 that cycle, IDLE next, next grant goes to requester 0.
